// File: rtl/chroni_pkg.sv
// rtl/chroni_pkg.sv - shared chroni types, default widths and VGA mode constants
package chroni_pkg;

  localparam int CHRONI_ADDR_W      = 11;
  localparam int CHRONI_DATA_W      = 8;
  localparam int CHRONI_WFIFO_DEPTH = 4;

  // 640x480 @ 60 Hz timing, in pixel clocks / lines
  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_DRAIN = 2'd1,
    ST_RD_ISSUE = 2'd2,
    ST_RD_DATA  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/chroni_vram_arb_if.sv
// rtl/chroni_vram_arb_if.sv - CPU request/response bus into the VRAM arbiter
interface chroni_vram_arb_if
  import chroni_pkg::*;
#(
  parameter int ADDR_W = CHRONI_ADDR_W,
  parameter int DATA_W = CHRONI_DATA_W
);

  logic              cpu_wr;
  logic              cpu_rd;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;

  modport master (
    output cpu_wr, cpu_rd, cpu_addr, cpu_wdata,
    input  cpu_ready, cpu_rdata, cpu_rvalid
  );

  modport slave (
    input  cpu_wr, cpu_rd, cpu_addr, cpu_wdata,
    output cpu_ready, cpu_rdata, cpu_rvalid
  );

endinterface

// File: rtl/chroni_wfifo.sv
// rtl/chroni_wfifo.sv - CPU write buffer holding {addr, data} pairs for the VRAM arbiter
module chroni_wfifo
  import chroni_pkg::*;
#(
  parameter int DEPTH  = CHRONI_WFIFO_DEPTH,
  parameter int ADDR_W = CHRONI_ADDR_W,
  parameter int DATA_W = CHRONI_DATA_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge vga_clk) begin
    if (do_push) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/chroni_vram_arb.sv
// rtl/chroni_vram_arb.sv - single-port VRAM arbiter: video reads first, buffered CPU writes, ordered CPU reads
module chroni_vram_arb
  import chroni_pkg::*;
#(
  parameter int ADDR_W      = CHRONI_ADDR_W,
  parameter int DATA_W      = CHRONI_DATA_W,
  parameter int WFIFO_DEPTH = CHRONI_WFIFO_DEPTH
) (
  input  logic                vga_clk,
  input  logic                reset_n,
  input  logic                video_rd,
  input  logic [ADDR_W-1:0]   video_addr,
  output logic [DATA_W-1:0]   video_data,
  chroni_vram_arb_if.slave    cpu,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int CNT_W = $clog2(WFIFO_DEPTH) + 1;

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              push;
  logic              pop;
  logic              rd_accept;
  logic              rd_issue;

  chroni_wfifo #(
    .DEPTH  (WFIFO_DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wfifo (
    .vga_clk   (vga_clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_addr (cpu.cpu_addr),
    .push_data (cpu.cpu_wdata),
    .pop       (pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // The RAM output belongs to whoever owned the previous cycle; video reads it raw
  assign video_data = mem_rdata;

  // Memory port mux: video always wins, the read slot and buffered writes share the rest
  always_comb begin
    mem_addr  = mem_addr_q;
    mem_we    = 1'b0;
    mem_wdata = head_data;
    pop       = 1'b0;
    rd_issue  = 1'b0;
    if (video_rd) begin
      mem_addr = video_addr;
    end else if (reset_n) begin
      if (state == ST_RD_ISSUE) begin
        mem_addr = rd_addr_q;
        rd_issue = 1'b1;
      end else if (!fifo_empty) begin
        mem_addr = head_addr;
        mem_we   = 1'b1;
        pop      = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    cpu.cpu_ready = 1'b0;
    push          = 1'b0;
    rd_accept     = 1'b0;
    if (reset_n) begin
      case (state)
        ST_IDLE: begin
          // A read takes the handshake; a simultaneous write waits for a later cycle
          if (cpu.cpu_rd) begin
            cpu.cpu_ready = 1'b1;
            rd_accept     = 1'b1;
            state_nxt     = ST_RD_DRAIN;
          end else begin
            cpu.cpu_ready = !fifo_full;
            push          = cpu.cpu_wr && !fifo_full;
          end
        end
        ST_RD_DRAIN: if (fifo_count == '0) state_nxt = ST_RD_ISSUE;
        ST_RD_ISSUE: if (rd_issue)         state_nxt = ST_RD_DATA;
        ST_RD_DATA:                        state_nxt = ST_IDLE;
        default:                           state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      rd_addr_q      <= '0;
      mem_addr_q     <= '0;
      cpu.cpu_rdata  <= '0;
      cpu.cpu_rvalid <= 1'b0;
    end else begin
      state          <= state_nxt;
      mem_addr_q     <= mem_addr;
      cpu.cpu_rvalid <= (state == ST_RD_DATA);
      if (rd_accept)            rd_addr_q     <= cpu.cpu_addr;
      if (state == ST_RD_DATA)  cpu.cpu_rdata <= mem_rdata;
    end
  end

endmodule

// File: doc/chroni_vram_arb.md
CHRONI_VRAM_ARB -- requirements
Module: chroni_vram_arb

Interface
REQ-001 The block SHALL expose parameter ADDR_W, default 11, VRAM address width.
REQ-002 The block SHALL expose parameter DATA_W, default 8, VRAM data width.
REQ-003 The block SHALL expose parameter WFIFO_DEPTH, default 4, CPU write-buffer entries (power of two, at least 2).
REQ-004 Port vga_clk, input, 1: the single clock for all logic; one clock, no other clock domains.
REQ-005 Port reset_n, input, 1: reset, synchronous and active-low.
REQ-006 Port video_rd, input, 1: video read request this cycle.
REQ-007 Port video_addr, input, ADDR_W: video read address.
REQ-008 Port video_data, output, DATA_W: video read data.
REQ-009 Port cpu_wr, input, 1: CPU write request.
REQ-010 Port cpu_rd, input, 1: CPU read request.
REQ-011 Port cpu_addr, input, ADDR_W: CPU address.
REQ-012 Port cpu_wdata, input, DATA_W: CPU write data.
REQ-013 Port cpu_ready, output, 1: the CPU request is accepted this cycle.
REQ-014 Port cpu_rdata, output, DATA_W: CPU read data.
REQ-015 Port cpu_rvalid, output, 1: cpu_rdata is valid; 1-cycle pulse.
REQ-016 Port mem_addr, output, ADDR_W: address to the synchronous RAM.
REQ-017 Port mem_we, output, 1: write enable to the RAM.
REQ-018 Port mem_wdata, output, DATA_W: write data to the RAM.
REQ-019 Port mem_rdata, input, DATA_W: RAM read data, valid 1 cycle after its address.

Function
REQ-020 Video SHALL have absolute priority: when video_rd=1, mem_addr=video_addr and mem_we=0 in the same cycle (combinational).
REQ-021 video_data SHALL equal mem_rdata, giving video read latency of exactly 1 cycle, unchanged by CPU traffic.
REQ-022 A CPU write SHALL be accepted when cpu_wr=1 and cpu_ready=1; {cpu_addr, cpu_wdata} are pushed into the write FIFO.
REQ-023 cpu_ready for a write SHALL be 1 whenever the FIFO is not full and the FSM is in IDLE.
REQ-024 When video_rd=0 and the FIFO is not empty, the head entry SHALL drive mem_addr, mem_wdata and mem_we=1, and SHALL pop the entry that cycle.
REQ-025 A push and a pop in the same cycle SHALL leave the occupancy count unchanged.
REQ-026 A push and a pop in the same cycle when full SHALL still be refused, because cpu_ready=0 when full.
REQ-027 FIFO read and write pointers SHALL wrap modulo WFIFO_DEPTH.
REQ-028 The occupancy count SHALL be log2(WFIFO_DEPTH)+1 bits wide.
REQ-029 The FSM SHALL have the states IDLE, RD_DRAIN, RD_ISSUE and RD_DATA.
REQ-030 From IDLE, cpu_rd=1 SHALL latch cpu_addr, assert cpu_ready for 1 cycle, and move to RD_DRAIN.
REQ-031 If cpu_rd=1 and cpu_wr=1 together, the read SHALL be taken and the write SHALL be held off (cpu_ready covers the read only).
REQ-032 RD_DRAIN SHALL stay until the FIFO is empty (read-after-write ordering), then go to RD_ISSUE.
REQ-033 RD_ISSUE SHALL wait for a cycle with video_rd=0, drive the latched address with mem_we=0, then go to RD_DATA.
REQ-034 RD_DATA SHALL register mem_rdata into cpu_rdata, pulse cpu_rvalid=1, and return to IDLE.
REQ-035 cpu_ready SHALL be 0 in RD_DRAIN, RD_ISSUE and RD_DATA.
REQ-036 When there is no access, mem_we SHALL be 0 and mem_addr SHALL hold its last value.
REQ-037 Continuous video_rd=1 SHALL stall the CPU indefinitely; video SHALL never be starved.

Reset
REQ-038 On reset_n=0 at a clock edge: FIFO emptied, FSM=IDLE, cpu_rvalid=0, cpu_rdata=0, cpu_ready=0, mem_we=0.
REQ-039 A reset in the middle of an operation SHALL discard buffered writes and any pending read without a memory write.
REQ-040 Video passthrough (REQ-020, REQ-021) SHALL remain functional during reset.

Structure
REQ-041 The FSM state encodings and the default widths SHALL live in a shared package chroni_pkg, alongside the VGA mode constants.
REQ-042 The write FIFO SHALL be one sub-module, chroni_wfifo, with push, pop, full, empty and count.

Verification
REQ-043 Video read: video_rd=1, addr 0x400, RAM[0x400]=0x41 -> video_data=0x41 one cycle later.
REQ-044 Video priority: video_rd=1 every cycle for 100 cycles while 4 CPU writes are buffered -> no mem_we and no video_data error.
REQ-045 Write buffering: 5 back-to-back writes with video_rd=1 -> 4 accepted, cpu_ready=0 on the 5th; video_rd drops -> 4 writes in order.
REQ-046 Hazard: write 0x55 to 0x010, then immediately read 0x010 -> cpu_rvalid with cpu_rdata=0x55.
REQ-047 Simultaneous push and pop at count 2 -> count stays 2, pointers wrap correctly past depth.
REQ-048 Reset asserted while in RD_ISSUE with 3 buffered writes -> no mem_we, count=0, IDLE, no cpu_rvalid.
